uart_tx_io: RTL and testbench
=============================

# uart_tx_io

Memory-mapped UART transmitter peripheral: the responder end of the CPU's IO write path and the serial-out counterpart to the board's UART receive link. The CPU stores a byte through the IO address decode, the block queues it in a small FIFO, and it serialises the byte on `txd` as 8N1 at a fixed baud rate. It sits beside the switch and LED peripherals, is selected by its own chip-select from the IO decoder, and exposes a status word the CPU can poll with a load.

## Interface
- `CLKS_PER_BIT`, 200: clock cycles per bit, 23 MHz / 115200 rounded; legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte queue depth; power of two, 2–16.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `uartcs`  in  1  chip-select from the IO address decoder.
- `uartwrite`  in  1  IO write strobe, qualified by `uartcs`.
- `uartread`  in  1  IO read strobe, qualified by `uartcs`.
- `uartaddr`  in  2  register select, taken from the low address bits.
- `uart_wdata`  in  16  write data; only `[7:0]` is used.
- `uart_rdata`  out  16  status word; combinational while `uartcs && uartread`, otherwise 0.
- `txd`  out  1  serial output; idles high.

## Operation
- Register map, selected by `uartaddr`:
  - 2'b00 write: push `uart_wdata[7:0]` into the FIFO.
  - 2'b10 read: status = {13'b0, overflow, busy, full}.
  - All other accesses are ignored and read 0.
- Push rules:
  - A push happens when `uartcs && uartwrite && uartaddr==2'b00` is sampled at an edge.
  - If `full` is set before that edge, the byte is dropped and sticky `overflow` is set. A pop in the same cycle does not rescue the byte.
- Status flags:
  - `overflow` clears on the edge that completes a status read, i.e. one with `uartcs && uartread && uartaddr==2'b10`.
  - If an overflow and a status read happen in the same cycle, `overflow` ends up set.
  - `busy` = FSM not IDLE, or FIFO not empty.
- FSM states: IDLE, START, DATA, PARITY (only when the configuration macro below is defined), STOP.
  - IDLE → START when the FIFO is non-empty. The pop and the load of the shift register happen on that same edge.
  - START holds `txd`=0 for `CLKS_PER_BIT` cycles, then goes to DATA.
  - DATA shifts LSB first, 8 bits, each held `CLKS_PER_BIT` cycles. A 3-bit counter tracks the bit index. After bit 7 it goes to PARITY if enabled, otherwise to STOP.
  - STOP holds `txd`=1 for `CLKS_PER_BIT` cycles. It then goes directly to START if the FIFO is non-empty (back-to-back frames, no idle gap), otherwise to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 and is cleared on every state transition.
  - Width is `$clog2(CLKS_PER_BIT)`.
  - A bit ends when the counter equals `CLKS_PER_BIT`-1.
- FIFO:
  - Read and write pointers have one extra wrap bit.
  - full/empty are derived from pointer compare. Pointers wrap modulo `2*FIFO_DEPTH`.

## Timing
- Reset values:
  - `txd`=1, state IDLE, FIFO empty, pointers 0, counters 0.
  - `overflow`=0, `uart_rdata`=0 when not selected.
- Reset mid-frame aborts immediately. `txd` returns high asynchronously and the queued bytes are lost.
- Latency:
  - Push at edge N into an empty, idle block.
  - START is entered at edge N+1.
  - `txd` falls in the cycle after edge N+1.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- `busy` rises the cycle after the push edge. It falls on the edge that ends STOP with the FIFO empty.
- `full` reflects the pointer state after the last edge; it is a registered comparison, with no bypass.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in and sends even parity, the XOR of the 8 data bits, for one bit time.
  - Status bit 3 reads 1, so software can detect the build.
- `UART_TX_PARITY_EN` undefined: DATA goes directly to STOP and status bit 3 reads 0.

## Structure
- Shared IO package holds:
  - the register offsets `UART_DATA_OFS`=2'b00 and `UART_STAT_OFS`=2'b10;
  - the status bit positions;
  - the FSM state enum.
- One sub-module, `uart_tx_fifo`: a parameterised synchronous byte FIFO with push, pop, full, empty, dout and an active-low async reset.
- The FSM, baud counter and register decode live in `uart_tx_io`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset release, no access → `txd`=1 constant and status reads 16'h0000.
- Push 8'hA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `busy`=1 throughout, 0 after 40 cycles.
- Five pushes back-to-back while idle:
  - The first is popped immediately, so the FIFO holds four and no overflow occurs.
  - A sixth push is dropped, and status reads 16'h0007 (overflow, busy, full).
  - The next status read returns overflow=0.
- Push 8'h01, 8'h02 → two frames with no idle cycle between the STOP of the first and the START of the second. Total 80 cycles.
- Assert `rst`=0 during DATA bit 3 of 8'hFF → `txd`=1 within the same cycle; after release status=0 and no further frame is sent.
- With `UART_TX_PARITY_EN`: push 8'h07 → parity bit 1, frame of 44 cycles, status bit 3=1.

Source files
------------

// File: rtl/uart_tx_io_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_io_pkg
// Shared IO definitions for the UART transmitter peripheral: register offsets,
// status word bit positions and the transmit FSM state encoding.
// Configuration: UART_TX_PARITY_EN adds the PARITY state to the encoding.
// -----------------------------------------------------------------------------
package uart_tx_io_pkg;

  localparam logic [1:0] UART_DATA_OFS = 2'b00;
  localparam logic [1:0] UART_STAT_OFS = 2'b10;

  localparam int ST_FULL_BIT = 0;
  localparam int ST_BUSY_BIT = 1;
  localparam int ST_OVF_BIT  = 2;
  localparam int ST_PAR_BIT  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
`ifdef UART_TX_PARITY_EN
    ,
    S_PARITY = 3'd3
`endif
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO between the CPU write port and the transmit FSM.
// Pointers carry one extra wrap bit so full and empty come straight from a
// pointer compare. Pushes while full and pops while empty are ignored.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset (pointers to 0, FIFO empty)
//   push_i   write din_i at the write pointer
//   din_i    data in
//   pop_i    advance the read pointer
//   dout_o   entry at the read pointer (valid when not empty)
//   full_o   FIFO holds DEPTH entries
//   empty_o  FIFO holds no entries
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Same slot, opposite lap: the writer is exactly one lap ahead.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_tx_io.sv
// -----------------------------------------------------------------------------
// uart_tx_io
// Memory-mapped UART transmitter. The CPU pushes bytes through the IO decode
// into a small FIFO; the FSM serialises them on txd as 8N1 (or 8E1 when
// UART_TX_PARITY_EN is defined) at CLKS_PER_BIT clocks per bit.
//
// Register map (uartaddr):
//   2'b00 write : push uart_wdata[7:0]
//   2'b10 read  : {12'b0, parity_build, overflow, busy, full}
//   others      : ignored, read 0
//
// State table:
//   IDLE   | txd high, waiting for a queued byte
//   START  | start bit (txd low)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (UART_TX_PARITY_EN builds only)
//   STOP   | stop bit (txd high); chains straight into START if more queued
//
// Ports:
//   clock       clock
//   rst         asynchronous active-low reset
//   uartcs      chip select from the IO decoder
//   uartwrite   write strobe
//   uartread    read strobe
//   uartaddr    register select
//   uart_wdata  write data ([7:0] used)
//   uart_rdata  status word, 0 unless a status read is selected
//   txd         serial output, idles high
// -----------------------------------------------------------------------------
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        uartcs,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [1:0]  uartaddr,
  input  logic [15:0] uart_wdata,
  output logic [15:0] uart_rdata,
  output logic        txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        ovf_q, ovf_d;

  logic        push_req;
  logic        stat_rd;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        bit_end;
  logic        busy;
  logic [15:0] status;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^uart_wdata[15:8];

  assign push_req = uartcs && uartwrite && (uartaddr == UART_DATA_OFS);
  assign stat_rd  = uartcs && uartread  && (uartaddr == UART_STAT_OFS);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rst),
    .push_i  (push_req),
    .din_i   (uart_wdata[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_end = (cnt_q == BIT_LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d  = S_START;
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          par_d    = ^fifo_dout;
          cnt_d    = '0;
          bit_d    = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain the next frame with no idle gap when bytes are waiting.
          if (!fifo_empty) begin
            state_d  = S_START;
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            par_d    = ^fifo_dout;
            bit_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // txd is registered from the next state so it changes on the same edge
    // as the state and cannot glitch.
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // A drop in the same cycle as a status read wins, so it is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_rd) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    status              = '0;
    status[ST_FULL_BIT] = fifo_full;
    status[ST_BUSY_BIT] = busy;
    status[ST_OVF_BIT]  = ovf_q;
`ifdef UART_TX_PARITY_EN
    status[ST_PAR_BIT]  = 1'b1;
`endif
  end

  assign uart_rdata = stat_rd ? status : 16'h0000;

endmodule

// File: tb/tb_uart_tx_io.sv
module tb_uart_tx_io;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [15:0] PAR_ST     = 16'h0008;
  localparam bit          PAR_EN     = 1'b1;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [15:0] PAR_ST     = 16'h0000;
  localparam bit          PAR_EN     = 1'b0;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        uartcs = 1'b0;
  logic        uartwrite = 1'b0;
  logic        uartread = 1'b0;
  logic [1:0]  uartaddr = 2'b00;
  logic [15:0] uart_wdata = 16'h0000;
  logic [15:0] uart_rdata;
  logic        txd;

  int tests = 0;
  int fails = 0;

  uart_tx_io #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .uartcs     (uartcs),
    .uartwrite  (uartwrite),
    .uartread   (uartread),
    .uartaddr   (uartaddr),
    .uart_wdata (uart_wdata),
    .uart_rdata (uart_rdata),
    .txd        (txd)
  );

  always #5 clock = ~clock;

  task automatic idle_bus();
    uartcs = 1'b0; uartwrite = 1'b0; uartread = 1'b0;
    uartaddr = 2'b00; uart_wdata = 16'h0000;
  endtask

  task automatic select_status();
    uartcs = 1'b1; uartwrite = 1'b0; uartread = 1'b1; uartaddr = 2'b10;
  endtask

  // Called at a negedge; the write is captured on the following posedge and
  // the task returns at the negedge after it.
  task automatic push_byte(input logic [7:0] b);
    uartcs = 1'b1; uartwrite = 1'b1; uartaddr = 2'b00; uart_wdata = {8'h00, b};
    @(negedge clock);
    idle_bus();
  endtask

  // Expected line level for frame bit idx of byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && PAR_EN) return ^b;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", txd); end
    select_status();
    #1;
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL reset_status_in_rst: got %h expected %h", uart_rdata, PAR_ST); end
    idle_bus();
    @(negedge clock);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock); #1;
      tests++;
      if (txd !== 1'b1) begin fails++; $display("FAIL reset_idle_txd: cycle %0d got %b expected 1", k, txd); end
    end
    select_status();
    #1;
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL reset_status: got %h expected %h", uart_rdata, PAR_ST); end
    uartaddr = 2'b01;
    #1;
    tests++;
    if (uart_rdata !== 16'h0000) begin fails++; $display("FAIL unmapped_read: got %h expected 0000", uart_rdata); end
    uartaddr = 2'b10; uartcs = 1'b0;
    #1;
    tests++;
    if (uart_rdata !== 16'h0000) begin fails++; $display("FAIL unselected_read: got %h expected 0000", uart_rdata); end
    idle_bus();
    @(negedge clock);
  endtask

  task automatic test_frame_a5();
    bit exp_bits [11];
`ifdef UART_TX_PARITY_EN
    exp_bits = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
`else
    exp_bits = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1};
`endif
    push_byte(8'hA5);
    select_status();
    #1;
    tests++;
    if (uart_rdata[1] !== 1'b1) begin fails++; $display("FAIL a5_busy_after_push: got %b expected 1", uart_rdata[1]); end
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL a5_txd_before_start: got %b expected 1", txd); end
    @(negedge clock);
    for (int k = 0; k < FRAME; k++) begin
      #1;
      tests++;
      if (txd !== exp_bits[k/CPB]) begin
        fails++; $display("FAIL a5_txd: sample %0d got %b expected %b", k, txd, exp_bits[k/CPB]);
      end
      tests++;
      if (uart_rdata[1] !== 1'b1) begin
        fails++; $display("FAIL a5_busy: sample %0d got %b expected 1", k, uart_rdata[1]);
      end
      @(negedge clock);
    end
    #1;
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL a5_busy_fall: got %h expected %h", uart_rdata, PAR_ST); end
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL a5_txd_idle: got %b expected 1", txd); end
    idle_bus();
    @(negedge clock);
  endtask

  task automatic test_overflow();
    int k;
    uartcs = 1'b1; uartwrite = 1'b1; uartaddr = 2'b00;
    for (int i = 0; i < 6; i++) begin
      uart_wdata = 16'h0010 + 16'(i);
      @(negedge clock);
    end
    idle_bus();
    select_status();
    #1;
    tests++;
    if (uart_rdata !== (16'h0007 | PAR_ST)) begin
      fails++; $display("FAIL ovf_status: got %h expected %h", uart_rdata, 16'h0007 | PAR_ST);
    end
    @(negedge clock);
    #1;
    tests++;
    if (uart_rdata !== (16'h0003 | PAR_ST)) begin
      fails++; $display("FAIL ovf_cleared: got %h expected %h", uart_rdata, 16'h0003 | PAR_ST);
    end
    // Busy must fall exactly five frames after the first push edge.
    k = 6;
    while (k < 600) begin
      @(negedge clock);
      k++;
      #1;
      if (uart_rdata[1] == 1'b0) break;
    end
    tests++;
    if (k != 1 + 5 * FRAME) begin
      fails++; $display("FAIL ovf_drain_cycles: got %0d expected %0d", k, 1 + 5 * FRAME);
    end
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL ovf_after_drain: got %h expected %h", uart_rdata, PAR_ST); end
    idle_bus();
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic       e;
    uartcs = 1'b1; uartwrite = 1'b1; uartaddr = 2'b00; uart_wdata = 16'h0001;
    @(negedge clock);
    uart_wdata = 16'h0002;
    @(negedge clock);
    idle_bus();
    select_status();
    for (int k = 0; k < 2 * FRAME; k++) begin
      #1;
      b = (k < FRAME) ? 8'h01 : 8'h02;
      e = frame_bit(b, (k % FRAME) / CPB);
      tests++;
      if (txd !== e) begin fails++; $display("FAIL b2b_txd: sample %0d got %b expected %b", k, txd, e); end
      @(negedge clock);
    end
    #1;
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL b2b_busy_fall: got %h expected %h", uart_rdata, PAR_ST); end
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL b2b_txd_idle: got %b expected 1", txd); end
    idle_bus();
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    uartcs = 1'b1; uartwrite = 1'b1; uartaddr = 2'b00; uart_wdata = 16'h00FF;
    @(negedge clock);
    uart_wdata = 16'h0055;
    @(negedge clock);
    idle_bus();
    select_status();
    // Sample 0 is the first start-bit cycle; data bit 3 spans samples 16..19.
    repeat (17) @(negedge clock);
    #1;
    tests++;
    if (uart_rdata[1] !== 1'b1) begin fails++; $display("FAIL mid_busy_before_rst: got %b expected 1", uart_rdata[1]); end
    rst = 1'b0;
    #1;
    tests++;
    if (txd !== 1'b1) begin fails++; $display("FAIL mid_rst_txd: got %b expected 1", txd); end
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL mid_rst_status: got %h expected %h", uart_rdata, PAR_ST); end
    @(negedge clock);
    @(negedge clock);
    rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock); #1;
      tests++;
      if (txd !== 1'b1) begin fails++; $display("FAIL mid_no_frame: cycle %0d got %b expected 1", k, txd); end
    end
    tests++;
    if (uart_rdata !== PAR_ST) begin fails++; $display("FAIL mid_status_after: got %h expected %h", uart_rdata, PAR_ST); end
    idle_bus();
    @(negedge clock);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit exp_bits [11];
    exp_bits = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    push_byte(8'h07);
    select_status();
    #1;
    tests++;
    if (uart_rdata[3] !== 1'b1) begin fails++; $display("FAIL par_status_bit3: got %b expected 1", uart_rdata[3]); end
    @(negedge clock);
    for (int k = 0; k < 44; k++) begin
      #1;
      tests++;
      if (txd !== exp_bits[k/CPB]) begin
        fails++; $display("FAIL par_txd: sample %0d got %b expected %b", k, txd, exp_bits[k/CPB]);
      end
      @(negedge clock);
    end
    #1;
    tests++;
    if (uart_rdata !== 16'h0008) begin fails++; $display("FAIL par_busy_fall: got %h expected 0008", uart_rdata); end
    idle_bus();
    @(negedge clock);
  endtask
`endif

  initial begin
    idle_bus();
    test_reset();
    test_frame_a5();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
